// File: rtl/oc8051_fetch_buf_pkg.sv
// ---------------------------------------------------------------------------
// oc8051_fetch_buf_pkg
// Shared definitions for the 8051 instruction fetch buffer:
//   - fetch FSM state encoding
//   - default reset PC and external-fetch timeout
//   - pc_step(): PC advance by instruction length (len 0 counts as 1)
// ---------------------------------------------------------------------------
package oc8051_fetch_buf_pkg;

    typedef enum logic [1:0] {
        FS_ROM_REQ  = 2'd0,
        FS_ROM_DATA = 2'd1,
        FS_EXT      = 2'd2,
        FS_HOLD     = 2'd3
    } fetch_state_e;

    localparam logic [15:0] RST_PC_DEF      = 16'h0000;
    localparam int          EXT_TIMEOUT_DEF = 255;

    // Next PC after consuming an instruction of length len; wraps at 2^16.
    function automatic logic [15:0] pc_step(input logic [15:0] pc, input logic [1:0] len);
        logic [15:0] step;
        step = (len == 2'd0) ? 16'd1 : {14'd0, len};
        return pc + step;
    endfunction

endpackage

// File: rtl/oc8051_fetch_buf_ext_fetch.sv
// ---------------------------------------------------------------------------
// oc8051_ext_fetch
// Byte-serial external program-memory collector. Gathers three consecutive
// bytes starting at i_start_addr using a stb/ack handshake.
// Ports:
//   clk, rst       clock, async active-low reset
//   i_start        load start address and raise strobe (one cycle)
//   i_start_addr   address of the first byte
//   i_abort        redirect request; the in-flight byte is discarded
//   i_ack, i_data  external ack pulse and its data byte
//   o_stb, o_addr  external request strobe and byte address
//   o_done         3rd byte acked this cycle (o_bytes valid this cycle)
//   o_drop         an ack was discarded because of an abort
//   o_tmo          timeout expires this cycle; strobe drops at the edge
//   o_bytes        {byte2, byte1, byte0}; byte0 is at the start address
// ---------------------------------------------------------------------------
module oc8051_ext_fetch #(
    parameter int EXT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_start_addr,
    input  logic        i_abort,
    input  logic        i_ack,
    input  logic [7:0]  i_data,
    output logic        o_stb,
    output logic [15:0] o_addr,
    output logic        o_done,
    output logic        o_drop,
    output logic        o_tmo,
    output logic [23:0] o_bytes
);

    localparam logic [7:0] TO_LAST = 8'(EXT_TIMEOUT - 1);

    logic        r_stb;
    logic [15:0] r_addr;
    logic [1:0]  r_cnt;
    logic [7:0]  r_b0, r_b1;
    logic        r_pend;
    logic [7:0]  r_tcnt;

    logic w_kill, w_ack;

    // An abort arriving now or one still pending kills the in-flight byte.
    assign w_kill  = r_pend | i_abort;
    assign w_ack   = r_stb & i_ack;

    assign o_stb   = r_stb;
    assign o_addr  = r_addr;
    assign o_done  = w_ack & ~w_kill & (r_cnt == 2'd2);
    assign o_drop  = w_ack & w_kill;
    assign o_tmo   = r_stb & ~i_ack & (r_tcnt == TO_LAST);
    // Third byte is forwarded straight from the bus so the caller can
    // register the whole window on the ack edge.
    assign o_bytes = {i_data, r_b1, r_b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stb  <= 1'b0;
            r_addr <= 16'h0000;
            r_cnt  <= 2'd0;
            r_b0   <= 8'h00;
            r_b1   <= 8'h00;
            r_pend <= 1'b0;
            r_tcnt <= 8'd0;
        end else if (i_start) begin
            r_stb  <= 1'b1;
            r_addr <= i_start_addr;
            r_cnt  <= 2'd0;
            r_pend <= 1'b0;
            r_tcnt <= 8'd0;
        end else if (r_stb) begin
            if (i_ack) begin
                r_tcnt <= 8'd0;
                if (w_kill) begin
                    r_stb  <= 1'b0;
                    r_pend <= 1'b0;
                end else begin
                    if (r_cnt == 2'd0) r_b0 <= i_data;
                    if (r_cnt == 2'd1) r_b1 <= i_data;
                    r_cnt  <= r_cnt + 2'd1;
                    r_addr <= r_addr + 16'd1;
                    if (r_cnt == 2'd2) r_stb <= 1'b0;
                end
            end else if (o_tmo) begin
                // Timeout is the only case where the strobe drops mid-handshake.
                r_stb  <= 1'b0;
                r_pend <= 1'b0;
                r_tcnt <= 8'd0;
            end else begin
                r_tcnt <= r_tcnt + 8'd1;
                // Strobe must stay up until the outstanding ack returns.
                if (i_abort) r_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/oc8051_fetch_buf.sv
// ---------------------------------------------------------------------------
// oc8051_fetch_buf
// Instruction fetch buffer between program memory and decode. Owns the fetch
// PC, reads a 3-byte window from internal ROM or, when the address is not
// internal, byte-serially from external memory, and presents it to the
// decoder with an op_valid/consume handshake. pc_load redirects fetch.
// Ports:
//   clk, rst            clock, async active-low reset
//   rom_addr, ea_int    internal ROM address (=pc) and "address is internal"
//   data1..data3        ROM bytes at rom_addr..+2, one-cycle latency
//   ext_addr, ext_stb   external byte address / request
//   ext_ack, ext_data   external ack pulse / data byte
//   pc_load, pc_new     branch redirect
//   consume, len        decoder accepts window; instruction length (0 -> 1)
//   op1..op3, op_valid  instruction window and its valid
//   pc                  address of op1
//   fetch_err           sticky external timeout flag (cleared by pc_load)
// ---------------------------------------------------------------------------
module oc8051_fetch_buf
    import oc8051_fetch_buf_pkg::*;
#(
    parameter logic [15:0] RST_PC      = RST_PC_DEF,
    parameter int          EXT_TIMEOUT = EXT_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    input  logic        ea_int,
    input  logic [7:0]  data1,
    input  logic [7:0]  data2,
    input  logic [7:0]  data3,
    output logic [15:0] ext_addr,
    output logic        ext_stb,
    input  logic        ext_ack,
    input  logic [7:0]  ext_data,
    input  logic        pc_load,
    input  logic [15:0] pc_new,
    input  logic        consume,
    input  logic [1:0]  len,
    output logic [7:0]  op1,
    output logic [7:0]  op2,
    output logic [7:0]  op3,
    output logic        op_valid,
    output logic [15:0] pc,
    output logic        fetch_err
);

    fetch_state_e r_state;
    logic [15:0]  r_pc;
    logic [7:0]   r_op1, r_op2, r_op3;
    logic         r_op_valid;
    logic         r_fetch_err;

    logic         w_start, w_done, w_drop, w_tmo;
    logic [23:0]  w_bytes;

    // ea_int is sampled on the ROM_REQ edge; a redirect in the same cycle
    // keeps us in ROM_REQ instead of launching a stale external fetch.
    assign w_start = (r_state == FS_ROM_REQ) & ~pc_load & ~ea_int;

    oc8051_ext_fetch #(
        .EXT_TIMEOUT (EXT_TIMEOUT)
    ) u_ext (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_start_addr (r_pc),
        .i_abort      (pc_load),
        .i_ack        (ext_ack),
        .i_data       (ext_data),
        .o_stb        (ext_stb),
        .o_addr       (ext_addr),
        .o_done       (w_done),
        .o_drop       (w_drop),
        .o_tmo        (w_tmo),
        .o_bytes      (w_bytes)
    );

    assign rom_addr  = r_pc;
    assign pc        = r_pc;
    assign op1       = r_op1;
    assign op2       = r_op2;
    assign op3       = r_op3;
    assign op_valid  = r_op_valid;
    assign fetch_err = r_fetch_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FS_ROM_REQ;
            r_pc        <= RST_PC;
            r_op1       <= 8'h00;
            r_op2       <= 8'h00;
            r_op3       <= 8'h00;
            r_op_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
        end else if (pc_load) begin
            r_pc        <= pc_new;
            r_op_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
            // In EXT the strobe is still up unless the ack or a timeout
            // ends it this cycle; otherwise wait there for the ack to drain.
            if (r_state != FS_EXT || w_drop || w_tmo)
                r_state <= FS_ROM_REQ;
        end else begin
            case (r_state)
                FS_ROM_REQ: begin
                    r_state <= ea_int ? FS_ROM_DATA : FS_EXT;
                end
                FS_ROM_DATA: begin
                    r_op1      <= data1;
                    r_op2      <= data2;
                    r_op3      <= data3;
                    r_op_valid <= 1'b1;
                    r_state    <= FS_HOLD;
                end
                FS_EXT: begin
                    if (w_drop) begin
                        r_state <= FS_ROM_REQ;
                    end else if (w_tmo) begin
                        // Stall in HOLD with no valid window until redirected.
                        r_fetch_err <= 1'b1;
                        r_state     <= FS_HOLD;
                    end else if (w_done) begin
                        r_op1      <= w_bytes[7:0];
                        r_op2      <= w_bytes[15:8];
                        r_op3      <= w_bytes[23:16];
                        r_op_valid <= 1'b1;
                        r_state    <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (consume && r_op_valid) begin
                        r_pc       <= pc_step(r_pc, len);
                        r_op_valid <= 1'b0;
                        r_state    <= FS_ROM_REQ;
                    end
                end
                default: r_state <= FS_ROM_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_oc8051_fetch_buf.sv
// ---------------------------------------------------------------------------
// tb_oc8051_fetch_buf
// Self-checking bench: ROM and external memory are byte arrays; the expected
// window is the three bytes at the model PC taken from whichever memory the
// PC maps to (internal below INT_LIM).
// ---------------------------------------------------------------------------
module tb_oc8051_fetch_buf;

    localparam int          TO      = 4;
    localparam logic [15:0] INT_LIM = 16'h0080;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] rom_addr, ext_addr, pc_new, pc;
    logic        ea_int, ext_stb, ext_ack, pc_load, consume, op_valid, fetch_err;
    logic [7:0]  data1, data2, data3, ext_data, op1, op2, op3;
    logic [1:0]  len;

    logic [7:0]  rom  [0:65535];
    logic [7:0]  xmem [0:65535];

    int          chk  = 0;
    int          errs = 0;
    logic [15:0] m_pc;

    always #5 clk = ~clk;

    oc8051_fetch_buf #(.RST_PC(16'h0000), .EXT_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .ea_int(ea_int),
        .data1(data1), .data2(data2), .data3(data3),
        .ext_addr(ext_addr), .ext_stb(ext_stb), .ext_ack(ext_ack), .ext_data(ext_data),
        .pc_load(pc_load), .pc_new(pc_new), .consume(consume), .len(len),
        .op1(op1), .op2(op2), .op3(op3), .op_valid(op_valid), .pc(pc),
        .fetch_err(fetch_err)
    );

    // Internal ROM: registered, one-cycle latency, 3-byte window.
    always @(posedge clk) begin
        data1 <= rom[rom_addr];
        data2 <= rom[rom_addr + 16'd1];
        data3 <= rom[rom_addr + 16'd2];
    end

    always_comb ea_int = (rom_addr < INT_LIM);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte k of the window starting at a, from the memory a maps to.
    function automatic logic [7:0] mbyte(input logic [15:0] a, input int k);
        logic [15:0] x;
        x = a + 16'(k);
        return (a < INT_LIM) ? rom[x] : xmem[x];
    endfunction

    task automatic check_window(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".rom_addr"}, rom_addr, m_pc);
        check({tag, ".op1"}, op1, mbyte(m_pc, 0));
        check({tag, ".op2"}, op2, mbyte(m_pc, 1));
        check({tag, ".op3"}, op3, mbyte(m_pc, 2));
    endtask

    task automatic do_consume(input logic [1:0] l);
        consume = 1'b1;
        len     = l;
        m_pc    = 16'(m_pc + ((l == 2'd0) ? 1 : int'(l)));
    endtask

    task automatic do_load(input logic [15:0] a);
        pc_load = 1'b1;
        pc_new  = a;
        m_pc    = a;
    endtask

    // Clears one-shot inputs each cycle, serves external acks with 0..3 idle
    // cycles, then checks latency, the ext address sequence and the window.
    task automatic run_fetch(input string tag, input int exp_lat);
        int   c, bi, gap, last_ack;
        logic got;
        c = 0; bi = 0; last_ack = -10; got = 1'b0;
        gap = $urandom_range(0, 3);
        while (!got && c < 60) begin
            @(negedge clk);
            c++;
            consume = 1'b0; pc_load = 1'b0; ext_ack = 1'b0;
            if (op_valid) begin
                got = 1'b1;
            end else if (ext_stb) begin
                if (gap == 0) begin
                    check({tag, ".ext_addr"}, ext_addr, 16'(m_pc + 16'(bi)));
                    ext_data = xmem[ext_addr];
                    ext_ack  = 1'b1;
                    bi++;
                    last_ack = c;
                    gap = $urandom_range(0, 3);
                end else begin
                    gap--;
                end
            end
        end
        check({tag, ".valid"}, got, 1);
        if (got) begin
            if (m_pc < INT_LIM) begin
                check({tag, ".lat_int"}, c, exp_lat);
                check({tag, ".nacks"}, bi, 0);
            end else begin
                check({tag, ".lat_ext"}, c, last_ack + 1);
                check({tag, ".nacks"}, bi, 3);
            end
            check_window(tag);
        end
    endtask

    task automatic wait_stb(input string tag);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            consume = 1'b0; pc_load = 1'b0; ext_ack = 1'b0;
            c++;
        end while (!ext_stb && c < 10);
        check({tag, ".stb_rise"}, ext_stb, 1);
    endtask

    initial begin
        int          n, r;
        logic [15:0] a;
        ext_ack = 1'b0; ext_data = 8'h00; pc_load = 1'b0; pc_new = 16'h0000;
        consume = 1'b0; len = 2'd0;
        for (int i = 0; i < 65536; i++) begin
            rom[i]  = 8'($urandom);
            xmem[i] = 8'($urandom);
        end
        rom[0] = 8'h74; rom[1] = 8'h48; rom[2] = 8'hF5; rom[3] = 8'h99; rom[4] = 8'h74;
        xmem[16'h0080] = 8'hAA; xmem[16'h0081] = 8'hBB; xmem[16'h0082] = 8'hCC;
        m_pc = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.pc", pc, 16'h0000);
        check("rst.op_valid", op_valid, 0);
        check("rst.ext_stb", ext_stb, 0);
        check("rst.ext_addr", ext_addr, 16'h0000);
        check("rst.fetch_err", fetch_err, 0);
        check("rst.ops", {op1, op2, op3}, 24'h0);

        // 1: first internal fetch two cycles after release
        rst = 1'b1;
        run_fetch("t1", 2);
        check("t1.op", {op1, op2, op3}, 24'h7448F5);

        // 2: consume len=2, then len=0 (advances by 1)
        do_consume(2'd2);
        run_fetch("t2a", 3);
        check("t2a.op", {op1, op2, op3}, 24'hF59974);
        do_consume(2'd0);
        run_fetch("t2b", 3);
        check("t2b.pc", pc, 16'h0003);

        // 3: redirect to external memory
        do_load(16'h0080);
        run_fetch("t3", 0);
        check("t3.op", {op1, op2, op3}, 24'hAABBCC);

        // 4: redirect while the 2nd external byte is outstanding
        do_load(16'h0100);
        wait_stb("t4");
        ext_data = xmem[ext_addr]; ext_ack = 1'b1;
        @(negedge clk);
        ext_ack = 1'b0;
        check("t4.addr2", ext_addr, 16'h0101);
        do_load(16'h0040);
        @(negedge clk);
        pc_load = 1'b0;
        check("t4.stb_hold1", ext_stb, 1);
        check("t4.addr_hold", ext_addr, 16'h0101);
        check("t4.pc", pc, 16'h0040);
        check("t4.valid_lo", op_valid, 0);
        @(negedge clk);
        check("t4.stb_hold2", ext_stb, 1);
        @(negedge clk);
        check("t4.stb_hold3", ext_stb, 1);
        ext_data = 8'h5A; ext_ack = 1'b1;
        @(negedge clk);
        ext_ack = 1'b0;
        check("t4.stb_drop", ext_stb, 0);
        check("t4.rom_addr", rom_addr, 16'h0040);
        check("t4.valid_lo2", op_valid, 0);
        run_fetch("t4", 2);

        // 5: external window wrapping through 0000
        do_load(16'hFFFF);
        run_fetch("t5", 0);
        do_consume(2'd1);
        run_fetch("t5b", 3);
        check("t5b.pc", pc, 16'h0000);

        // 6: external timeout, stall, recovery by pc_load
        do_load(16'h0200);
        wait_stb("t6");
        n = 0;
        while (ext_stb && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("t6.stb_cycles", n, TO);
        check("t6.err", fetch_err, 1);
        check("t6.valid", op_valid, 0);
        consume = 1'b1; len = 2'd1;
        @(negedge clk);
        consume = 1'b0;
        @(negedge clk);
        check("t6.stall_valid", op_valid, 0);
        check("t6.stall_stb", ext_stb, 0);
        check("t6.stall_err", fetch_err, 1);
        check("t6.stall_pc", pc, 16'h0200);
        do_load(16'h0000);
        @(negedge clk);
        pc_load = 1'b0;
        check("t6.err_clr", fetch_err, 0);
        run_fetch("t6b", 2);

        // Randomized traffic: consumes, redirects, and redirect racing consume
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(0, 16'h007F));
            else                           a = 16'($urandom);
            if (r < 6) begin
                do_consume(2'($urandom_range(0, 3)));
            end else if (r < 9) begin
                do_load(a);
            end else begin
                consume = 1'b1; len = 2'($urandom_range(0, 3));
                do_load(a);
            end
            run_fetch("rnd", 3);
        end

        // Asynchronous reset while an external request is outstanding
        do_load(16'h0300);
        wait_stb("rmid");
        #2 rst = 1'b0;
        #1;
        check("rmid.stb", ext_stb, 0);
        check("rmid.pc", pc, 16'h0000);
        check("rmid.valid", op_valid, 0);
        check("rmid.ext_addr", ext_addr, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
